handshake_elastic_fifo: RTL and testbench

- Opaque elastic FIFO buffer stage placed directly downstream of handshake constant/operator units in the dataflow netlist.
- Consumes a valid/ready data channel, stores up to SLOTS tokens, and re-issues them in order on a valid/ready output channel.
- Breaks the combinational valid, data and ready paths between producer and consumer. Also absorbs backpressure bursts so constant units can keep firing.

---
 rtl/handshake_elastic_fifo_pkg.sv | 24 ++
 rtl/handshake_elastic_fifo_if.sv | 39 +++
 rtl/handshake_elastic_fifo_storage.sv | 25 ++
 rtl/handshake_elastic_fifo.sv | 89 ++++++++
 tb/tb_handshake_elastic_fifo.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/handshake_elastic_fifo_pkg.sv
// Shared constants and elaboration-time helpers for the handshake elastic FIFO.
package handshake_elastic_fifo_pkg;

    localparam int unsigned HANDSHAKE_FIFO_MAX_SLOTS = 256;

    function automatic int unsigned fifo_clog2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        while ((64'd1 << bits) < 64'(value)) begin
            bits++;
        end
        return bits;
    endfunction

    // Pointers keep at least one bit so a single-slot FIFO still has a legal vector.
    function automatic int unsigned fifo_ptr_width(input int unsigned slots);
        return (slots > 1) ? fifo_clog2(slots) : 1;
    endfunction

    function automatic bit fifo_slots_legal(input int unsigned slots);
        return (slots >= 1) && (slots <= HANDSHAKE_FIFO_MAX_SLOTS);
    endfunction

endpackage

// File: rtl/handshake_elastic_fifo_if.sv
// Producer/consumer channel bundle of the elastic FIFO; slave is the FIFO's view.
interface handshake_elastic_fifo_if
    import handshake_elastic_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SLOTS      = 4
) ();

    localparam int unsigned CNT_W = fifo_clog2(SLOTS + 1);

    logic [DATA_WIDTH-1:0] ins;
    logic                  ins_valid;
    logic                  ins_ready;
    logic [DATA_WIDTH-1:0] outs;
    logic                  outs_valid;
    logic                  outs_ready;
    logic [CNT_W-1:0]      occupancy;

    modport slave (
        input  ins,
        input  ins_valid,
        output ins_ready,
        output outs,
        output outs_valid,
        input  outs_ready,
        output occupancy
    );

    modport master (
        output ins,
        output ins_valid,
        input  ins_ready,
        input  outs,
        input  outs_valid,
        output outs_ready,
        input  occupancy
    );

endinterface

// File: rtl/handshake_elastic_fifo_storage.sv
// Token register array: synchronous write port, asynchronous read port, no reset.
module handshake_fifo_storage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SLOTS      = 4,
    parameter int unsigned ADDR_W     = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [SLOTS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/handshake_elastic_fifo.sv
// Opaque elastic FIFO: every channel output is driven from registered state only.
module handshake_elastic_fifo
    import handshake_elastic_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SLOTS      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    handshake_elastic_fifo_if.slave bus
);

    localparam int unsigned CNT_W = fifo_clog2(SLOTS + 1);
    localparam int unsigned PTR_W = fifo_ptr_width(SLOTS);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SLOTS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SLOTS);

    if (!fifo_slots_legal(SLOTS)) begin : g_slots_check
        $error("handshake_elastic_fifo: SLOTS=%0d outside 1..%0d", SLOTS, HANDSHAKE_FIFO_MAX_SLOTS);
    end

    if (DATA_WIDTH < 1) begin : g_width_check
        $error("handshake_elastic_fifo: DATA_WIDTH must be at least 1");
    end

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  active_q;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head_data;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

    // active_q keeps ins_ready low through reset and the release cycle without
    // giving rst a combinational path to the producer.
    assign push = bus.ins_valid && active_q && !full;
    assign pop  = bus.outs_ready && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            active_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            active_q <= 1'b1;
        end
    end

    handshake_fifo_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .SLOTS      (SLOTS),
        .ADDR_W     (PTR_W)
    ) u_storage (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (bus.ins),
        .raddr (rd_ptr_q),
        .rdata (head_data)
    );

    assign bus.ins_ready  = active_q && !full;
    assign bus.outs_valid = !empty;
    assign bus.outs       = empty ? '0 : head_data;
    assign bus.occupancy  = count_q;

endmodule

// File: tb/tb_handshake_elastic_fifo.sv
// Bench for handshake_elastic_fifo at SLOTS=4 and SLOTS=3 against a queue model.
module tb_handshake_elastic_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    handshake_elastic_fifo_if #(.DATA_WIDTH(32), .SLOTS(4)) if4 ();
    handshake_elastic_fifo_if #(.DATA_WIDTH(32), .SLOTS(3)) if3 ();

    handshake_elastic_fifo #(.DATA_WIDTH(32), .SLOTS(4)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (if4.slave)
    );

    handshake_elastic_fifo #(.DATA_WIDTH(32), .SLOTS(3)) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: each FIFO is a bounded queue of tokens; m_active follows "ready from
    // the first edge after reset release".
    logic [31:0] q4[$];
    logic [31:0] q3[$];
    bit          m_active = 1'b0;

    function automatic logic [31:0] head4();
        return (q4.size() != 0) ? q4[0] : 32'h0;
    endfunction

    function automatic logic [31:0] head3();
        return (q3.size() != 0) ? q3[0] : 32'h0;
    endfunction

    task automatic drive4(input logic v, input logic [31:0] d, input logic r);
        if4.ins_valid = v; if4.ins = d; if4.outs_ready = r;
    endtask

    task automatic drive3(input logic v, input logic [31:0] d, input logic r);
        if3.ins_valid = v; if3.ins = d; if3.outs_ready = r;
    endtask

    task automatic clock_edge();
        bit p4, o4, p3, o3;
        logic [31:0] d4, d3;
        p4 = m_active && rst && if4.ins_valid && (q4.size() < 4);
        o4 = rst && if4.outs_ready && (q4.size() > 0);
        p3 = m_active && rst && if3.ins_valid && (q3.size() < 3);
        o3 = rst && if3.outs_ready && (q3.size() > 0);
        d4 = if4.ins;
        d3 = if3.ins;
        @(posedge clk);
        #1;
        if (o4) void'(q4.pop_front());
        if (p4) q4.push_back(d4);
        if (o3) void'(q3.pop_front());
        if (p3) q3.push_back(d3);
        if (rst) m_active = 1'b1;
    endtask

    a_outs_hold4: assert property (@(posedge clk) disable iff (!rst)
        (if4.outs_valid && !if4.outs_ready) |=> (if4.outs_valid && if4.outs == $past(if4.outs)))
        else $error("outs hold violated on SLOTS=4 instance");
    a_outs_hold3: assert property (@(posedge clk) disable iff (!rst)
        (if3.outs_valid && !if3.outs_ready) |=> (if3.outs_valid && if3.outs == $past(if3.outs)))
        else $error("outs hold violated on SLOTS=3 instance");
    a_ins_hold4: assert property (@(posedge clk) disable iff (!rst)
        (if4.ins_valid && !if4.ins_ready) |=> (if4.ins_valid && $stable(if4.ins)))
        else $error("producer released an unaccepted token on SLOTS=4 instance");
    a_ins_hold3: assert property (@(posedge clk) disable iff (!rst)
        (if3.ins_valid && !if3.ins_ready) |=> (if3.ins_valid && $stable(if3.ins)))
        else $error("producer released an unaccepted token on SLOTS=3 instance");

    task automatic test_reset();
        drive4(1'b1, 32'hA5A5_0001, 1'b1);
        drive3(1'b0, 32'h0, 1'b0);
        #2 rst = 1'b0;
        q4.delete(); q3.delete(); m_active = 1'b0;
        for (int c = 0; c < 3; c++) begin
            clock_edge();
            n_cmp++; if (if4.ins_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ins_ready c%0d: got %b want 0", c, if4.ins_ready); end
            n_cmp++; if (if4.outs_valid !== 1'b0) begin n_bad++; $display("FAIL reset_outs_valid c%0d: got %b want 0", c, if4.outs_valid); end
            n_cmp++; if (if4.outs !== 32'h0) begin n_bad++; $display("FAIL reset_outs c%0d: got %h want 0", c, if4.outs); end
            n_cmp++; if (if4.occupancy !== 3'd0) begin n_bad++; $display("FAIL reset_occupancy c%0d: got %0d want 0", c, if4.occupancy); end
            n_cmp++; if (if3.ins_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ins_ready3 c%0d: got %b want 0", c, if3.ins_ready); end
        end
        rst = 1'b1;
        clock_edge();
        n_cmp++; if (if4.ins_ready !== 1'b1) begin n_bad++; $display("FAIL release_ins_ready: got %b want 1", if4.ins_ready); end
        n_cmp++; if (if4.occupancy !== 3'd0) begin n_bad++; $display("FAIL release_no_push: got %0d want 0", if4.occupancy); end
        clock_edge();
        n_cmp++; if (if4.occupancy !== 3'd1) begin n_bad++; $display("FAIL first_push_occ: got %0d want 1", if4.occupancy); end
        n_cmp++; if (if4.outs !== 32'hA5A5_0001) begin n_bad++; $display("FAIL first_push_outs: got %h want a5a50001", if4.outs); end
        drive4(1'b0, 32'h0, 1'b1);
        clock_edge();
        n_cmp++; if (if4.outs_valid !== 1'b0) begin n_bad++; $display("FAIL first_pop_valid: got %b want 0", if4.outs_valid); end
        drive4(1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_stall();
        drive4(1'b1, 32'h2E70_5901, 1'b0);
        clock_edge();
        drive4(1'b0, 32'h0, 1'b0);
        n_cmp++; if (if4.outs_valid !== 1'b1) begin n_bad++; $display("FAIL stall_valid: got %b want 1", if4.outs_valid); end
        n_cmp++; if (if4.occupancy !== 3'd1) begin n_bad++; $display("FAIL stall_occ: got %0d want 1", if4.occupancy); end
        for (int c = 0; c < 10; c++) begin
            clock_edge();
            n_cmp++; if (if4.outs !== 32'h2E70_5901 || if4.outs_valid !== 1'b1) begin
                n_bad++; $display("FAIL stall_hold c%0d: got %b/%h want 1/2e705901", c, if4.outs_valid, if4.outs);
            end
        end
        drive4(1'b0, 32'h0, 1'b1);
        clock_edge();
        drive4(1'b0, 32'h0, 1'b0);
        n_cmp++; if (if4.outs_valid !== 1'b0 || if4.outs !== 32'h0 || if4.occupancy !== 3'd0) begin
            n_bad++; $display("FAIL stall_drain: got %b/%h/%0d want 0/0/0", if4.outs_valid, if4.outs, if4.occupancy);
        end
    endtask

    task automatic test_full_backpressure();
        for (int i = 1; i <= 5; i++) begin
            drive4(1'b1, 32'(i), 1'b0);
            clock_edge();
            n_cmp++; if (if4.occupancy !== 3'((i < 4) ? i : 4)) begin
                n_bad++; $display("FAIL fill_occ i%0d: got %0d want %0d", i, if4.occupancy, (i < 4) ? i : 4);
            end
            n_cmp++; if (if4.ins_ready !== (i < 4)) begin
                n_bad++; $display("FAIL fill_ready i%0d: got %b want %b", i, if4.ins_ready, i < 4);
            end
        end
        drive4(1'b1, 32'd5, 1'b1);
        #1;
        n_cmp++; if (if4.ins_ready !== 1'b0) begin n_bad++; $display("FAIL same_cycle_ready: got %b want 0", if4.ins_ready); end
        clock_edge();
        n_cmp++; if (if4.occupancy !== 3'd3) begin n_bad++; $display("FAIL pop_full_occ: got %0d want 3", if4.occupancy); end
        n_cmp++; if (if4.ins_ready !== 1'b1) begin n_bad++; $display("FAIL next_cycle_ready: got %b want 1", if4.ins_ready); end
        n_cmp++; if (if4.outs !== 32'd2) begin n_bad++; $display("FAIL pop_full_head: got %h want 2", if4.outs); end
        drive4(1'b1, 32'd5, 1'b0);
        clock_edge();
        n_cmp++; if (if4.occupancy !== 3'd4) begin n_bad++; $display("FAIL refill_occ: got %0d want 4", if4.occupancy); end
        for (int k = 2; k <= 5; k++) begin
            n_cmp++; if (if4.outs !== 32'(k)) begin n_bad++; $display("FAIL drain_order k%0d: got %h want %h", k, if4.outs, k); end
            drive4(1'b0, 32'h0, 1'b1);
            clock_edge();
        end
        drive4(1'b0, 32'h0, 1'b0);
        n_cmp++; if (if4.outs_valid !== 1'b0 || if4.occupancy !== 3'd0) begin
            n_bad++; $display("FAIL drain_empty: got %b/%0d want 0/0", if4.outs_valid, if4.occupancy);
        end
    endtask

    task automatic test_back_to_back();
        int bad_seq = 0;
        drive4(1'b1, 32'd0, 1'b1);
        for (int k = 0; k < 100; k++) begin
            clock_edge();
            n_cmp++; if (if4.outs !== 32'(k) || if4.outs_valid !== 1'b1 || if4.occupancy !== 3'd1) begin
                n_bad++; bad_seq++;
                if (bad_seq <= 5) $display("FAIL b2b k%0d: got %b/%h/%0d want 1/%h/1", k, if4.outs_valid, if4.outs, if4.occupancy, k);
            end
            drive4(k < 99, 32'(k + 1), 1'b1);
        end
        clock_edge();
        drive4(1'b0, 32'h0, 1'b0);
        n_cmp++; if (if4.outs_valid !== 1'b0 || if4.occupancy !== 3'd0) begin
            n_bad++; $display("FAIL b2b_end: got %b/%0d want 0/0", if4.outs_valid, if4.occupancy);
        end
    endtask

    task automatic test_async_reset();
        drive4(1'b1, 32'h11, 1'b0); clock_edge();
        drive4(1'b1, 32'h22, 1'b0); clock_edge();
        drive4(1'b1, 32'h33, 1'b0); clock_edge();
        drive4(1'b0, 32'h0, 1'b0);
        n_cmp++; if (if4.occupancy !== 3'd3) begin n_bad++; $display("FAIL prefill_occ: got %0d want 3", if4.occupancy); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (if4.outs_valid !== 1'b0) begin n_bad++; $display("FAIL async_valid: got %b want 0", if4.outs_valid); end
        n_cmp++; if (if4.occupancy !== 3'd0) begin n_bad++; $display("FAIL async_occ: got %0d want 0", if4.occupancy); end
        n_cmp++; if (if4.outs !== 32'h0) begin n_bad++; $display("FAIL async_outs: got %h want 0", if4.outs); end
        n_cmp++; if (if4.ins_ready !== 1'b0) begin n_bad++; $display("FAIL async_ready: got %b want 0", if4.ins_ready); end
        q4.delete(); q3.delete(); m_active = 1'b0;
        clock_edge();
        rst = 1'b1;
        clock_edge();
        drive4(1'b1, 32'h44, 1'b0); clock_edge();
        drive4(1'b1, 32'h55, 1'b0); clock_edge();
        drive4(1'b0, 32'h0, 1'b0);
        n_cmp++; if (if4.outs !== 32'h44 || if4.occupancy !== 3'd2) begin
            n_bad++; $display("FAIL post_reset_head: got %h/%0d want 44/2", if4.outs, if4.occupancy);
        end
        drive4(1'b0, 32'h0, 1'b1); clock_edge();
        n_cmp++; if (if4.outs !== 32'h55) begin n_bad++; $display("FAIL post_reset_second: got %h want 55", if4.outs); end
        clock_edge();
        drive4(1'b0, 32'h0, 1'b0);
        n_cmp++; if (if4.outs_valid !== 1'b0) begin n_bad++; $display("FAIL post_reset_empty: got %b want 0", if4.outs_valid); end
    endtask

    // Random producer/consumer on one instance; sel3 picks the SLOTS=3 one.
    task automatic test_random(input bit sel3, input int cycles);
        logic v = 1'b0;
        logic [31:0] d = '0;
        logic r, acc;
        int pushed = 0, popped = 0, bad_rnd = 0;
        int c = 0;
        while (c < cycles || ((v || (sel3 ? q3.size() : q4.size()) != 0) && c < cycles + 20)) begin
            if (!v && c < cycles) begin
                v = ($urandom_range(0, 3) != 0);
                d = $urandom;
            end
            r = (c < cycles) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sel3) drive3(v, d, r); else drive4(v, d, r);
            acc = v && (sel3 ? if3.ins_ready : if4.ins_ready);
            if (sel3 ? (if3.outs_valid && r) : (if4.outs_valid && r)) popped++;
            clock_edge();
            if (acc) begin v = 1'b0; pushed++; end
            if (sel3) begin
                n_cmp++; if (if3.outs_valid !== (q3.size() != 0) || if3.outs !== head3() ||
                             if3.occupancy !== 2'(q3.size()) || if3.ins_ready !== (q3.size() < 3)) begin
                    n_bad++; bad_rnd++;
                    if (bad_rnd <= 5) $display("FAIL rand3 c%0d: got v%b d%h o%0d r%b want v%b d%h o%0d r%b", c,
                        if3.outs_valid, if3.outs, if3.occupancy, if3.ins_ready, q3.size() != 0, head3(), q3.size(), q3.size() < 3);
                end
            end else begin
                n_cmp++; if (if4.outs_valid !== (q4.size() != 0) || if4.outs !== head4() ||
                             if4.occupancy !== 3'(q4.size()) || if4.ins_ready !== (q4.size() < 4)) begin
                    n_bad++; bad_rnd++;
                    if (bad_rnd <= 5) $display("FAIL rand4 c%0d: got v%b d%h o%0d r%b want v%b d%h o%0d r%b", c,
                        if4.outs_valid, if4.outs, if4.occupancy, if4.ins_ready, q4.size() != 0, head4(), q4.size(), q4.size() < 4);
                end
            end
            c++;
        end
        if (sel3) drive3(1'b0, 32'h0, 1'b0); else drive4(1'b0, 32'h0, 1'b0);
        n_cmp++; if (popped !== pushed || v) begin
            n_bad++; $display("FAIL rand_balance sel3=%0d: popped %0d pushed %0d pending %b", sel3, popped, pushed, v);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        drive4(1'b0, 32'h0, 1'b0);
        drive3(1'b0, 32'h0, 1'b0);
        test_reset();
        test_stall();
        test_full_backpressure();
        test_back_to_back();
        test_async_reset();
        test_random(1'b1, 20);
        test_random(1'b1, 60);
        test_random(1'b0, 150);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
